// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential 32-bit divider (div_seq).
package div_pkg;

    localparam int DATA_W    = 32;
    localparam int RESULT_W  = 64;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        DIV_ON  = 2'd2,
        DONE    = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_addsub64.sv
// 64-bit adder/subtractor with carry-out; carry-out=1 in sub mode means a >= b (no borrow).
module addsub64 (
    input  logic        sub,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        cout
);

    logic [64:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b ^ {64{sub}}} + {64'd0, sub};
    assign sum     = sum_ext[63:0];
    assign cout    = sum_ext[64];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider, one quotient bit per cycle (33-cycle latency).
// Optional macro DIV_SIGNED_EN enables signed DIV; without it every request is DIVU.
module div_seq
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]   divisor,
    input  logic                annul,
    output logic                ready,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid
);

    div_state_t           state, next_state;
    logic [CNT_W-1:0]     step_cnt;
    logic [RESULT_W-1:0]  part_rem;
    logic [DATA_W-1:0]    divisor_mag;
    logic [DATA_W-1:0]    mag_a, mag_b;
    logic [RESULT_W-1:0]  shifted, diff, part_next;
    logic                 cout, no_borrow;
    logic                 accept, last_step;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_r;

    assign a_neg = signed_div & dividend[DATA_W-1];
    assign b_neg = signed_div & divisor[DATA_W-1];
    assign mag_a = a_neg ? -dividend : dividend;
    assign mag_b = b_neg ? -divisor  : divisor;

    // Quotient negated on sign mismatch, remainder follows the dividend sign.
    function automatic logic [RESULT_W-1:0] sign_fix(input logic [RESULT_W-1:0] p,
                                                     input logic nq, input logic nr);
        logic [DATA_W-1:0] q, r;
        q = p[DATA_W-1:0];
        r = p[RESULT_W-1:DATA_W];
        if (nq) q = -q;
        if (nr) r = -r;
        return {r, q};
    endfunction
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div;
    assign mag_a = dividend;
    assign mag_b = divisor;

    function automatic logic [RESULT_W-1:0] sign_fix(input logic [RESULT_W-1:0] p);
        return p;
    endfunction
`endif

    assign accept    = (state == IDLE) && start && !annul;
    assign last_step = (step_cnt == CNT_W'(DIV_STEPS - 1));

    // Trial subtraction of {divisor,0} from the left-shifted partial remainder.
    assign shifted = {part_rem[RESULT_W-2:0], 1'b0};

    addsub64 u_addsub (
        .sub  (1'b1),
        .a    (shifted),
        .b    ({divisor_mag, {DATA_W{1'b0}}}),
        .sum  (diff),
        .cout (cout)
    );

    // The shifted-out MSB is the 65th bit of the trial value.
    assign no_borrow = part_rem[RESULT_W-1] | cout;
    assign part_next = no_borrow ? {diff[RESULT_W-1:1], 1'b1} : shifted;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (annul) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) next_state = (divisor == '0) ? DIVZERO : DIV_ON;
                DIVZERO: next_state = DONE;
                DIV_ON:  if (last_step) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ready        = (state == IDLE);
        result_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)                                  step_cnt <= '0;
        else if (accept)                          step_cnt <= '0;
        else if (state == DIV_ON && !annul)       step_cnt <= step_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            part_rem    <= {{DATA_W{1'b0}}, mag_a};
            divisor_mag <= mag_b;
`ifdef DIV_SIGNED_EN
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
`endif
        end else if (state == DIV_ON) begin
            part_rem    <= part_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (!annul) begin
            if (state == DIVZERO)
                result <= '0;
            else if (state == DIV_ON && last_step)
`ifdef DIV_SIGNED_EN
                result <= sign_fix(part_next, neg_q, neg_r);
`else
                result <= sign_fix(part_next);
`endif
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] dividend, divisor;
    logic        ready, result_valid;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .dividend     (dividend),
        .divisor      (divisor),
        .annul        (annul),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid)
    );

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
`ifdef DIV_SIGNED_EN
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
`endif
        return {a % b, a / b};
    endfunction

    // Launch one request and wait (bounded) for the completion pulse.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; signed_div = s; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_div = $urandom;
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid); end
        n_cmp++;
        if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_divu_basic;
        logic [63:0] res; int lat;
        do_op(32'd100, 32'd7, 1'b0, res, lat);
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", lat); end
        n_cmp++;
        if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL divu_pulse valid=%b ready=%b want 0/1", result_valid, ready);
        end
        n_cmp++;
        if (result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_hold got %h want %h", result, {32'd2, 32'd14}); end
    endtask

    task automatic test_signed;
        logic [63:0] res, exp; int lat;
`ifdef DIV_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
        exp = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        n_cmp++;
        if (res !== exp) begin n_fail++; $display("FAIL div_m7_2 got %h want %h", res, exp); end
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
        exp = {32'h0, 32'h8000_0000};
        n_cmp++;
        if (res !== exp) begin n_fail++; $display("FAIL div_min_m1 got %h want %h", res, exp); end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL div_min_m1_latency got %0d want 33", lat); end
`else
        do_op(32'hFFFF_FFF8, 32'd2, 1'b1, res, lat);
        exp = {32'h0, 32'h7FFF_FFFC};
        n_cmp++;
        if (res !== exp) begin n_fail++; $display("FAIL divu_forced_m8_2 got %h want %h", res, exp); end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL divu_forced_latency got %0d want 33", lat); end
`endif
    endtask

    task automatic test_divzero;
        logic [63:0] res; int lat;
        do_op(32'd5, 32'd0, 1'b0, res, lat);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL divzero_latency got %0d want 2", lat); end
        n_cmp++;
        if (res !== 64'h0) begin n_fail++; $display("FAIL divzero_result got %h want 0", res); end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL divzero_return valid=%b ready=%b want 0/1", result_valid, ready);
        end
    endtask

    task automatic test_annul;
        logic [63:0] res, prev; int lat; bit seen;
        do_op(32'd1000, 32'd3, 1'b0, prev, lat);
        @(negedge clk);
        start = 1'b1; dividend = 32'd12345; divisor = 32'd17;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL annul_ready got %b want 1", ready); end
        n_cmp++;
        if (result !== prev) begin n_fail++; $display("FAIL annul_result got %h want %h", result, prev); end
        // annul beats start in IDLE
        start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL annul_prio_ready got %b want 1", ready); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_no_valid got %b want 0", seen); end
        do_op(32'd77, 32'd5, 1'b0, res, lat);
        n_cmp++;
        if (res !== {32'd2, 32'd15} || lat !== 33) begin
            n_fail++; $display("FAIL annul_restart got %h lat %0d want %h lat 33", res, lat, {32'd2, 32'd15});
        end
    endtask

    task automatic test_start_ignored;
        logic [63:0] res; int lat;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd16;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd0;
        @(negedge clk);
        start = 1'b0;
        lat = 7;
        while (!result_valid && lat < 100) begin @(negedge clk); lat++; end
        res = result;
        n_cmp++;
        if (res !== {32'd15, 32'h0FFF_FFFF}) begin
            n_fail++; $display("FAIL start_ignored got %h want %h", res, {32'd15, 32'h0FFF_FFFF});
        end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL start_ignored_latency got %0d want 33", lat); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        start = 1'b1; dividend = 32'd999; divisor = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1; annul = 1'b1;
        @(negedge clk);
        rst = 1'b0; annul = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_valid got %b want 0", seen); end
        n_cmp++;
        if (result !== 64'h0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_state result=%h ready=%b want 0/1", result, ready);
        end
    endtask

    task automatic test_random;
        logic [63:0] res, exp; logic [31:0] a, b; logic s; int lat, exp_lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = (i % 8 == 2) ? 32'd0 : 32'hFFFF_FFFF;
                default: b = {16'd0, 16'($urandom)};
            endcase
            if (i % 6 == 5) a = 32'h8000_0000;
            s = $urandom;
            do_op(a, b, s, res, lat);
            exp     = ref_div(a, b, s);
            exp_lat = (b == 32'd0) ? 2 : 33;
            n_cmp++;
            if (res !== exp || lat !== exp_lat) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h s=%b got %h lat %0d want %h lat %0d",
                         i, a, b, s, res, lat, exp, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res1, res2; int lat1, lat2;
        do_op(32'd81, 32'd9, 1'b0, res1, lat1);
        do_op(32'd82, 32'd9, 1'b0, res2, lat2);
        n_cmp++;
        if (res1 !== {32'd0, 32'd9} || res2 !== {32'd1, 32'd9}) begin
            n_fail++; $display("FAIL back_to_back got %h %h want %h %h", res1, res2, {32'd0, 32'd9}, {32'd1, 32'd9});
        end
    endtask

    initial begin
        test_reset;
        test_divu_basic;
        test_signed;
        test_divzero;
        test_annul;
        test_start_ignored;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
